// File: rtl/bcd_serial_add_ctrl.sv
// Serial BCD adder controller: steps one shared external single-digit BCD adder
// across DIGITS digits, LSD first, rippling the carry through a register.
// Latency DIGITS+1 cycles from accepted start to the done pulse. Start is ignored while busy.
// Optional macro BCD_CHECK_EN adds the err port and rejects non-BCD operand digits at accept.
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [4*DIGITS-1:0]   i_a_in,
    input  logic [4*DIGITS-1:0]   i_b_in,
    input  logic                  i_cin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_sum_out,
    output logic                  o_cout,
`ifdef BCD_CHECK_EN
    output logic                  o_err,
`endif
    output logic [3:0]            o_add_a,
    output logic [3:0]            o_add_b,
    output logic                  o_add_cin,
    input  logic [3:0]            i_add_res,
    input  logic                  i_add_cout
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [IW-1:0]         r_idx;
    logic                  r_carry;
    logic [4*DIGITS-1:0]   r_a;
    logic [4*DIGITS-1:0]   r_b;
    logic [4*DIGITS-1:0]   r_sum;
    logic [4*DIGITS-1:0]   w_sum_next;
    logic                  w_accept;
    logic                  w_bad;

`ifdef BCD_CHECK_EN
    // True when any 4-bit digit of the operand is above 9.
    function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    assign w_bad = has_bad_digit(i_a_in) | has_bad_digit(i_b_in);
`else
    assign w_bad = 1'b0;
`endif

    // A start is only honoured when no operation is in flight.
    assign w_accept = i_start && (r_state == S_IDLE || r_state == S_DONE);

    // Drive the shared adder with the current digit pair; park it at zero otherwise.
    always_comb begin
        o_add_a   = 4'd0;
        o_add_b   = 4'd0;
        o_add_cin = 1'b0;
        if (r_state == S_RUN) begin
            o_add_a   = r_a[4*r_idx +: 4];
            o_add_b   = r_b[4*r_idx +: 4];
            o_add_cin = r_carry;
        end
    end

    // Partial sum with the current adder result merged into the active digit slot.
    always_comb begin
        w_sum_next = r_sum;
        w_sum_next[4*r_idx +: 4] = i_add_res;
    end

    // Control FSM with all host-facing outputs registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_carry   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_sum     <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_sum_out <= '0;
            o_cout    <= 1'b0;
`ifdef BCD_CHECK_EN
            o_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    o_done <= 1'b0;
                    if (w_accept) begin
                        r_a       <= i_a_in;
                        r_b       <= i_b_in;
                        r_carry   <= i_cin;
                        r_idx     <= '0;
                        r_sum     <= '0;
                        o_sum_out <= '0;
                        o_cout    <= 1'b0;
                        if (w_bad) begin
                            // Invalid digits: report immediately without using the adder.
                            r_state <= S_DONE;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
`ifdef BCD_CHECK_EN
                            o_err   <= 1'b1;
`endif
                        end else begin
                            r_state <= S_RUN;
                            o_busy  <= 1'b1;
`ifdef BCD_CHECK_EN
                            o_err   <= 1'b0;
`endif
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= i_add_cout;
                    if (r_idx == LAST_IDX) begin
                        r_state   <= S_DONE;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                        o_sum_out <= w_sum_next;
                        o_cout    <= i_add_cout;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl (DIGITS=4) with a behavioural single-digit BCD adder.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Define BCD_CHECK_EN to also exercise the invalid-digit path.
module tb_bcd_serial_add_ctrl;

    localparam int DIGITS = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [4*DIGITS-1:0]   a_in;
    logic [4*DIGITS-1:0]   b_in;
    logic                  cin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum_out;
    logic                  cout;
`ifdef BCD_CHECK_EN
    logic                  err;
`endif
    logic [3:0]            add_a;
    logic [3:0]            add_b;
    logic                  add_cin;
    logic [3:0]            add_res;
    logic                  add_cout;
    logic [4:0]            add_raw;

    int vectors = 0;
    int miscompares = 0;
    int ncyc;

    always #5 clk = ~clk;

    // External single-digit BCD adder
    assign add_raw  = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
    assign add_cout = (add_raw > 5'd9);
    assign add_res  = add_cout ? 4'(add_raw - 5'd10) : add_raw[3:0];

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_a_in     (a_in),
        .i_b_in     (b_in),
        .i_cin      (cin),
        .o_busy     (busy),
        .o_done     (done),
        .o_sum_out  (sum_out),
        .o_cout     (cout),
`ifdef BCD_CHECK_EN
        .o_err      (err),
`endif
        .o_add_a    (add_a),
        .o_add_b    (add_b),
        .o_add_cin  (add_cin),
        .i_add_res  (add_res),
        .i_add_cout (add_cout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ticks until done is seen, giving up after 20 cycles.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_sum", 32'(sum_out), 32'h0);
        chk("rst_cout", 32'(cout), 32'h0);
        chk("rst_add_a", 32'(add_a), 32'h0);
`ifdef BCD_CHECK_EN
        chk("rst_err", 32'(err), 32'h0);
`endif
        rst = 1'b0;
        tick();

        // 1: 1234 + 4321
        a_in = 16'h1234; b_in = 16'h4321; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy0", 32'(busy), 32'h1);
        chk("t1_add_a0", 32'(add_a), 32'h4);
        chk("t1_add_b0", 32'(add_b), 32'h1);
        tick();
        chk("t1_add_a1", 32'(add_a), 32'h3);
        tick();
        chk("t1_add_a2", 32'(add_a), 32'h2);
        tick();
        chk("t1_add_a3", 32'(add_a), 32'h1);
        chk("t1_busy3", 32'(busy), 32'h1);
        chk("t1_done3", 32'(done), 32'h0);
        tick();
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_busy_end", 32'(busy), 32'h0);
        chk("t1_sum", 32'(sum_out), 32'h5555);
        chk("t1_cout", 32'(cout), 32'h0);
        chk("t1_add_idle", 32'(add_a), 32'h0);
        tick();
        chk("t1_done_pulse", 32'(done), 32'h0);
        chk("t1_sum_hold", 32'(sum_out), 32'h5555);

        // 2: 9999 + 0001, carry ripples through every digit
        a_in = 16'h9999; b_in = 16'h0001; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_sum_clr", 32'(sum_out), 32'h0);
        wait_done(ncyc);
        chk("t2_lat", 32'(ncyc), 32'd4);
        chk("t2_sum", 32'(sum_out), 32'h0000);
        chk("t2_cout", 32'(cout), 32'h1);
        tick();

        // 3: 0000 + 0000 + cin, then back-to-back 0005 + 0005 from DONE
        a_in = 16'h0000; b_in = 16'h0000; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_cin", 32'(add_cin), 32'h1);
        wait_done(ncyc);
        chk("t3_lat", 32'(ncyc), 32'd4);
        chk("t3_sum", 32'(sum_out), 32'h0001);
        chk("t3_cout", 32'(cout), 32'h0);
        a_in = 16'h0005; b_in = 16'h0005; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_b2b_busy", 32'(busy), 32'h1);
        chk("t3_b2b_done", 32'(done), 32'h0);
        wait_done(ncyc);
        chk("t3_b2b_lat", 32'(ncyc), 32'd4);
        chk("t3_b2b_sum", 32'(sum_out), 32'h0010);
        chk("t3_b2b_cout", 32'(cout), 32'h0);
        tick();

        // 4: start during RUN is ignored
        a_in = 16'h0250; b_in = 16'h0750; cin = 1'b0; start = 1'b1;
        tick();
        a_in = 16'h1111; b_in = 16'h1111;
        tick();
        tick();
        start = 1'b0;
        wait_done(ncyc);
        chk("t4_lat", 32'(ncyc), 32'd2);
        chk("t4_sum", 32'(sum_out), 32'h1000);
        chk("t4_cout", 32'(cout), 32'h0);
        tick();
        chk("t4_single_done", 32'(done), 32'h0);
        chk("t4_idle_busy", 32'(busy), 32'h0);

        // 5: reset in the middle of RUN, then a fresh operation
        a_in = 16'h1234; b_in = 16'h1111; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_done", 32'(done), 32'h0);
        chk("t5_sum", 32'(sum_out), 32'h0);
        chk("t5_add", 32'({add_a, add_b, 3'b000, add_cin}), 32'h0);
        tick();
        chk("t5_stay_idle", 32'(busy), 32'h0);
        a_in = 16'h0008; b_in = 16'h0007; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(ncyc);
        chk("t5_lat", 32'(ncyc), 32'd4);
        chk("t5_sum", 32'(sum_out), 32'h0015);
        chk("t5_cout", 32'(cout), 32'h0);
        tick();

        // Top-digit carry out with no lower carries
        a_in = 16'h5000; b_in = 16'h7000; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(ncyc);
        chk("top_sum", 32'(sum_out), 32'h2000);
        chk("top_cout", 32'(cout), 32'h1);
        tick();

`ifdef BCD_CHECK_EN
        // 6: non-BCD digit rejected, then cleared by a valid op
        a_in = 16'h12A4; b_in = 16'h0001; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_done", 32'(done), 32'h1);
        chk("t6_err", 32'(err), 32'h1);
        chk("t6_sum", 32'(sum_out), 32'h0);
        chk("t6_cout", 32'(cout), 32'h0);
        tick();
        chk("t6_done_pulse", 32'(done), 32'h0);
        chk("t6_err_hold", 32'(err), 32'h1);
        a_in = 16'h0001; b_in = 16'h0001; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_err_clr", 32'(err), 32'h0);
        wait_done(ncyc);
        chk("t6_valid_sum", 32'(sum_out), 32'h0002);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
